// File: rtl/lifo.sv
// Ready/valid last-in-first-out stack with a shared push/pop end.
// Holds return addresses or any state that must unwind in reverse order.
module lifo #(
    parameter int N_ENTRIES   = 8,
    parameter int ENTRY_WIDTH = 32,
    parameter logic [N_ENTRIES*ENTRY_WIDTH-1:0] INIT_ENTRY_REG_STATE = '0,
    localparam int PTR_WIDTH  = $clog2(N_ENTRIES),
    localparam int CTR_WIDTH  = PTR_WIDTH + 1
) (
    input  logic                             clk,
    input  logic                             rst_aL,
    output logic                             push_ready,
    input  logic                             push_valid,
    input  logic [ENTRY_WIDTH-1:0]           push_data,
    input  logic                             pop_ready,
    output logic                             pop_valid,
    output logic [ENTRY_WIDTH-1:0]           pop_data,
    output logic [CTR_WIDTH-1:0]             count,
    input  logic                             init,
    input  logic [N_ENTRIES*ENTRY_WIDTH-1:0] init_entry_reg_state,
    input  logic [CTR_WIDTH-1:0]             init_sp_state
);

    logic [CTR_WIDTH-1:0]   sp_q, sp_d;
    logic [ENTRY_WIDTH-1:0] entry_q [N_ENTRIES];
    logic [N_ENTRIES-1:0]   entry_we;
    logic [PTR_WIDTH-1:0]   top_idx;
    logic [PTR_WIDTH-1:0]   wr_idx;
    logic                   full;
    logic                   empty;
    logic                   push;
    logic                   pop;

    // Sp counts valid entries, so the MSB alone marks the full state.
    assign full       = sp_q[CTR_WIDTH-1];
    assign empty      = (sp_q == '0);
    assign push_ready = !full;
    assign pop_valid  = !empty;
    assign push       = push_valid & push_ready;
    assign pop        = pop_valid & pop_ready;
    assign count      = sp_q;

    // Top wraps to N_ENTRIES-1 when empty, giving a stale but defined read.
    assign top_idx  = sp_q[PTR_WIDTH-1:0] - PTR_WIDTH'(1);
    assign pop_data = entry_q[top_idx];

    // Push alone writes above the top; push with pop replaces the top.
    assign wr_idx = pop ? top_idx : sp_q[PTR_WIDTH-1:0];

    // One-hot entry write enables, suppressed while init loads the array.
    always_comb begin
        entry_we = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            entry_we[i] = push & !init & (wr_idx == PTR_WIDTH'(i));
        end
    end

    // Stack pointer next state: init beats push/pop, replace-top holds.
    always_comb begin
        sp_d = sp_q;
        if (init) begin
            sp_d = init_sp_state;
        end else if (push && !pop) begin
            sp_d = sp_q + CTR_WIDTH'(1);
        end else if (pop && !push) begin
            sp_d = sp_q - CTR_WIDTH'(1);
        end
    end

    // Stack pointer register.
    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    for (genvar g = 0; g < N_ENTRIES; g++) begin : g_entry
        // Entry register: reset value, bulk init load, or a single write.
        always_ff @(posedge clk or negedge rst_aL) begin
            if (!rst_aL) begin
                entry_q[g] <= INIT_ENTRY_REG_STATE[g*ENTRY_WIDTH +: ENTRY_WIDTH];
            end else if (init) begin
                entry_q[g] <= init_entry_reg_state[g*ENTRY_WIDTH +: ENTRY_WIDTH];
            end else if (entry_we[g]) begin
                entry_q[g] <= push_data;
            end
        end
    end

endmodule

// File: tb/tb_lifo.sv
// Directed testbench for the lifo stack.
// Each task drives one scenario and checks inline.
module tb_lifo;

    localparam int N = 8;
    localparam int W = 32;
    localparam int CW = 4;

    logic            clk;
    logic            rst_aL;
    logic            push_ready;
    logic            push_valid;
    logic [W-1:0]    push_data;
    logic            pop_ready;
    logic            pop_valid;
    logic [W-1:0]    pop_data;
    logic [CW-1:0]   count;
    logic            init;
    logic [N*W-1:0]  init_entry_reg_state;
    logic [CW-1:0]   init_sp_state;

    int tests;
    int fails;

    lifo #(
        .N_ENTRIES  (N),
        .ENTRY_WIDTH(W)
    ) dut (
        .clk                 (clk),
        .rst_aL              (rst_aL),
        .push_ready          (push_ready),
        .push_valid          (push_valid),
        .push_data           (push_data),
        .pop_ready           (pop_ready),
        .pop_valid           (pop_valid),
        .pop_data            (pop_data),
        .count               (count),
        .init                (init),
        .init_entry_reg_state(init_entry_reg_state),
        .init_sp_state       (init_sp_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        push_valid = 1'b0;
        push_data  = '0;
        pop_ready  = 1'b0;
        init       = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_aL = 1'b0;
        step();
        rst_aL = 1'b1;
        step();
    endtask

    task automatic push_one(input logic [W-1:0] d);
        push_valid = 1'b1;
        push_data  = d;
        pop_ready  = 1'b0;
        step();
        idle();
    endtask

    task automatic test_reset();
        idle();
        init_entry_reg_state = '0;
        init_sp_state = '0;
        rst_aL = 1'b0;
        #3;
        tests++;
        if (count !== 4'd0 || pop_valid !== 1'b0 || push_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_during: count=%0d pop_valid=%b push_ready=%b required 0/0/1",
                     count, pop_valid, push_ready);
        end
        step();
        rst_aL = 1'b1;
        step();
        tests++;
        if (push_ready !== 1'b1 || pop_valid !== 1'b0 || count !== 4'd0) begin
            fails++;
            $display("FAIL reset_flags: push_ready=%b pop_valid=%b count=%0d required 1/0/0",
                     push_ready, pop_valid, count);
        end
        tests++;
        if (pop_data !== 32'h0) begin
            fails++;
            $display("FAIL reset_pop_data: got %h required 00000000", pop_data);
        end
        pop_ready = 1'b1;
        step();
        idle();
        tests++;
        if (count !== 4'd0 || pop_valid !== 1'b0) begin
            fails++;
            $display("FAIL pop_empty: count=%0d pop_valid=%b required 0/0", count, pop_valid);
        end
    endtask

    task automatic test_push_pop();
        logic [W-1:0] exp [3];
        exp[0] = 32'h33;
        exp[1] = 32'h22;
        exp[2] = 32'h11;
        do_reset();
        push_one(32'h11);
        tests++;
        if (pop_data !== 32'h11 || count !== 4'd1) begin
            fails++;
            $display("FAIL push_visible: pop_data=%h count=%0d required 11/1", pop_data, count);
        end
        push_one(32'h22);
        push_one(32'h33);
        tests++;
        if (count !== 4'd3 || pop_data !== 32'h33) begin
            fails++;
            $display("FAIL push3: count=%0d pop_data=%h required 3/33", count, pop_data);
        end
        pop_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (pop_data !== exp[i] || pop_valid !== 1'b1) begin
                fails++;
                $display("FAIL pop_seq[%0d]: pop_data=%h valid=%b required %h/1",
                         i, pop_data, pop_valid, exp[i]);
            end
            step();
        end
        idle();
        tests++;
        if (count !== 4'd0 || pop_valid !== 1'b0) begin
            fails++;
            $display("FAIL pop_drain: count=%0d pop_valid=%b required 0/0", count, pop_valid);
        end
    endtask

    task automatic fill_a0();
        do_reset();
        for (int i = 0; i < N; i++) begin
            push_one(32'hA0 + W'(i));
        end
    endtask

    task automatic test_full();
        fill_a0();
        tests++;
        if (count !== 4'd8 || push_ready !== 1'b0) begin
            fails++;
            $display("FAIL full: count=%0d push_ready=%b required 8/0", count, push_ready);
        end
        push_one(32'hFF);
        tests++;
        if (count !== 4'd8 || pop_data !== 32'hA7) begin
            fails++;
            $display("FAIL overflow: count=%0d pop_data=%h required 8/a7", count, pop_data);
        end
        pop_ready = 1'b1;
        step();
        idle();
        tests++;
        if (count !== 4'd7 || push_ready !== 1'b1 || pop_data !== 32'hA6) begin
            fails++;
            $display("FAIL pop_from_full: count=%0d push_ready=%b pop_data=%h required 7/1/a6",
                     count, push_ready, pop_data);
        end
    endtask

    task automatic test_replace();
        do_reset();
        push_one(32'hB0);
        push_one(32'hB1);
        push_valid = 1'b1;
        push_data  = 32'hC0;
        pop_ready  = 1'b1;
        #1;
        tests++;
        if (pop_data !== 32'hB1 || pop_valid !== 1'b1 || push_ready !== 1'b1) begin
            fails++;
            $display("FAIL replace_observe: pop_data=%h valid=%b ready=%b required b1/1/1",
                     pop_data, pop_valid, push_ready);
        end
        step();
        idle();
        tests++;
        if (count !== 4'd2 || pop_data !== 32'hC0) begin
            fails++;
            $display("FAIL replace_top: count=%0d pop_data=%h required 2/c0", count, pop_data);
        end
        pop_ready = 1'b1;
        step();
        idle();
        tests++;
        if (count !== 4'd1 || pop_data !== 32'hB0) begin
            fails++;
            $display("FAIL replace_below: count=%0d pop_data=%h required 1/b0", count, pop_data);
        end
    endtask

    task automatic test_boundary_both();
        do_reset();
        push_valid = 1'b1;
        push_data  = 32'hD0;
        pop_ready  = 1'b1;
        step();
        idle();
        tests++;
        if (count !== 4'd1 || pop_data !== 32'hD0) begin
            fails++;
            $display("FAIL empty_both: count=%0d pop_data=%h required 1/d0", count, pop_data);
        end
        fill_a0();
        push_valid = 1'b1;
        push_data  = 32'hEE;
        pop_ready  = 1'b1;
        step();
        idle();
        tests++;
        if (count !== 4'd7 || pop_data !== 32'hA6) begin
            fails++;
            $display("FAIL full_both: count=%0d pop_data=%h required 7/a6", count, pop_data);
        end
        push_one(32'h5A);
        tests++;
        if (count !== 4'd8 || pop_data !== 32'h5A) begin
            fails++;
            $display("FAIL refill: count=%0d pop_data=%h required 8/5a", count, pop_data);
        end
    endtask

    task automatic test_init_and_async_reset();
        do_reset();
        for (int i = 0; i < N; i++) begin
            init_entry_reg_state[i*W +: W] = W'(i);
        end
        init_sp_state = 4'd5;
        init       = 1'b1;
        push_valid = 1'b1;
        push_data  = 32'h99;
        pop_ready  = 1'b1;
        step();
        idle();
        tests++;
        if (count !== 4'd5 || pop_data !== 32'd4) begin
            fails++;
            $display("FAIL init_load: count=%0d pop_data=%h required 5/4", count, pop_data);
        end
        pop_ready = 1'b1;
        step();
        idle();
        tests++;
        if (count !== 4'd4 || pop_data !== 32'd3) begin
            fails++;
            $display("FAIL init_pop: count=%0d pop_data=%h required 4/3", count, pop_data);
        end
        push_valid = 1'b1;
        push_data  = 32'h77;
        #3;
        rst_aL = 1'b0;
        #1;
        tests++;
        if (count !== 4'd0 || pop_valid !== 1'b0 || push_ready !== 1'b1) begin
            fails++;
            $display("FAIL async_reset: count=%0d pop_valid=%b push_ready=%b required 0/0/1",
                     count, pop_valid, push_ready);
        end
        tests++;
        if (pop_data !== 32'h0) begin
            fails++;
            $display("FAIL async_reset_data: pop_data=%h required 00000000", pop_data);
        end
        idle();
        step();
        rst_aL = 1'b1;
        step();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_aL = 1'b1;
        idle();
        init_entry_reg_state = '0;
        init_sp_state = '0;
        test_reset();
        test_push_pop();
        test_full();
        test_replace();
        test_boundary_both();
        test_init_and_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
